// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int BE_WIDTH    = 4;   // byte enables at the default 32-bit data width

  typedef logic master_id_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Owner-ID FIFO: remembers which master issued each outstanding request so the
// response can be routed back. Simultaneous push and pop are allowed.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  logic       pop,
  input  master_id_t din,
  output master_id_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  master_id_t             slots [DEPTH];
  logic       [PTR_W-1:0] rd_ptr, wr_ptr;
  logic       [CNT_W-1:0] cnt;
  logic                   do_push, do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot being written, so a full FIFO can still accept a push alongside it.
  assign do_push = push & (~full | do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) slots[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between two cores,
// routing each response back to the master that issued the request.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [NUM_MASTERS-1:0]                       m_req_i,
  output logic [NUM_MASTERS-1:0]                       m_gnt_o,
  output logic [NUM_MASTERS-1:0]                       m_rvalid_o,
  input  logic [NUM_MASTERS-1:0]                       m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]     m_be_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]       m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]       m_wdata_i,
  output logic [DATA_WIDTH-1:0]                        m_rdata_o,
  output logic [NUM_MASTERS-1:0]                       m_err_o,
  output logic                                         s_req_o,
  input  logic                                         s_gnt_i,
  input  logic                                         s_rvalid_i,
  output logic                                         s_we_o,
  output logic [DATA_WIDTH/8-1:0]                      s_be_o,
  output logic [ADDR_WIDTH-1:0]                        s_addr_o,
  output logic [DATA_WIDTH-1:0]                        s_wdata_o,
  input  logic [DATA_WIDTH-1:0]                        s_rdata_i,
  input  logic                                         s_err_i,
  output logic                                         proto_err_o
);

  if (MAX_OUTSTANDING < 1) begin : g_bad_depth
    $error("mem_port_arbiter: MAX_OUTSTANDING must be at least 1");
  end

  master_id_t winner, last_q, lock_id_q, fifo_head;
  logic       lock_q, proto_err_q;
  logic       fifo_full, fifo_empty;
  logic       handshake, rsp;

  always_comb begin
    winner = ~last_q;
    if (lock_q) begin
      winner = lock_id_q;
    end else begin
      case (m_req_i)
        2'b01:   winner = 1'b0;
        2'b10:   winner = 1'b1;
        default: winner = ~last_q;
      endcase
    end
  end

  // A strictly full FIFO blocks new requests even if a response pops this cycle.
  assign s_req_o   = (|m_req_i) & ~fifo_full;
  assign handshake = s_req_o & s_gnt_i;
  assign rsp       = s_rvalid_i & ~fifo_empty;

  assign s_we_o    = m_we_i[winner];
  assign s_be_o    = m_be_i[winner];
  assign s_addr_o  = m_addr_i[winner];
  assign s_wdata_o = m_wdata_i[winner];
  assign m_rdata_o = s_rdata_i;

  always_comb begin
    m_gnt_o            = '0;
    m_gnt_o[winner]    = handshake;
    m_rvalid_o         = '0;
    m_rvalid_o[fifo_head] = rsp;
    m_err_o            = '0;
    m_err_o[fifo_head] = rsp & s_err_i;
  end

  // Lock holds the winner of a pending request so its fields never change
  // under the memory; it drops on handshake or when nobody requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      lock_id_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      lock_q    <= s_req_o & ~s_gnt_i;
      lock_id_q <= winner;
      if (handshake) last_q <= winner;
      if (s_rvalid_i && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_q;

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (handshake),
    .pop   (s_rvalid_i),
    .din   (winner),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with an owner/data scoreboard and a
// small memory model answering in request order.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_i;
  logic [1:0]            m_req_i, m_gnt_o, m_rvalid_o, m_we_i, m_err_o;
  logic [1:0][BW-1:0]    m_be_i;
  logic [1:0][AW-1:0]    m_addr_i;
  logic [1:0][DW-1:0]    m_wdata_i;
  logic [DW-1:0]         m_rdata_o, s_wdata_o, s_rdata_i;
  logic                  s_req_o, s_gnt_i, s_rvalid_i, s_we_o, s_err_i, proto_err_o;
  logic [BW-1:0]         s_be_o;
  logic [AW-1:0]         s_addr_o;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_err_i(s_err_i), .proto_err_o(proto_err_o)
  );

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       gnt;
    logic       rv;
    logic       err;
    logic [1:0] exp_gnt;
    logic       exp_sreq;
    logic       exp_win;
    logic       exp_perr;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] mem_q[$];
  vec_t        vt[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  logic [31:0] exp_addr  [2] = '{32'h0000_0100, 32'h0000_0040};
  logic [31:0] exp_wdata [2] = '{32'h1111_2222, 32'h3333_4444};
  logic [3:0]  exp_be    [2] = '{4'h3, 4'hF};
  logic        exp_we    [2] = '{1'b1, 1'b0};

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic gnt,
                              input logic rv, input logic err, input logic [1:0] eg,
                              input logic esr, input logic ew, input logic ep);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.rv = rv; v.err = err;
    v.exp_gnt = eg; v.exp_sreq = esr; v.exp_win = ew; v.exp_perr = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got 0x%0h want 0x%0h", nm, row, act, exp);
  endtask

  task automatic apply(input vec_t v, input int row);
    sb_t        e;
    logic [1:0] exp_rv, exp_err;
    @(negedge clk);
    rst_i      = v.rst;
    m_req_i    = v.req;
    s_gnt_i    = v.gnt;
    s_rvalid_i = v.rv;
    s_err_i    = v.err;
    s_rdata_i  = 32'h0BAD_0BAD;
    if (v.rv && mem_q.size() > 0) s_rdata_i = mem_q.pop_front();
    #1;
    exp_rv  = 2'b00;
    exp_err = 2'b00;
    if (v.rv && sb_q.size() > 0) begin
      e       = sb_q.pop_front();
      exp_rv  = e.id ? 2'b10 : 2'b01;
      exp_err = v.err ? exp_rv : 2'b00;
      chk("rdata", row, m_rdata_o, e.data);
    end
    chk("m_rvalid", row, 32'(m_rvalid_o), 32'(exp_rv));
    chk("m_err", row, 32'(m_err_o), 32'(exp_err));
    chk("m_gnt", row, 32'(m_gnt_o), 32'(v.exp_gnt));
    chk("s_req", row, 32'(s_req_o), 32'(v.exp_sreq));
    chk("proto_err", row, 32'(proto_err_o), 32'(v.exp_perr));
    if (v.exp_sreq) begin
      chk("s_addr", row, s_addr_o, exp_addr[v.exp_win]);
      chk("s_wdata", row, s_wdata_o, exp_wdata[v.exp_win]);
      chk("s_be", row, 32'(s_be_o), 32'(exp_be[v.exp_win]));
      chk("s_we", row, 32'(s_we_o), 32'(exp_we[v.exp_win]));
    end
    if (s_req_o && s_gnt_i) mem_q.push_back(rd_val(s_addr_o));
    if (v.exp_gnt != 2'b00)
      sb_q.push_back('{id: v.exp_gnt[1], data: rd_val(exp_addr[v.exp_gnt[1]])});
    if (v.rst) begin
      sb_q.delete();
      mem_q.delete();
    end
  endtask

  initial begin
    rst_i = 1'b1; m_req_i = '0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_err_i = 1'b0;
    s_rdata_i = '0;
    m_we_i    = {exp_we[1], exp_we[0]};
    m_be_i[0] = exp_be[0][BW-1:0];   m_be_i[1] = exp_be[1][BW-1:0];
    m_addr_i[0] = exp_addr[0];       m_addr_i[1] = exp_addr[1];
    m_wdata_i[0] = exp_wdata[0];     m_wdata_i[1] = exp_wdata[1];
    repeat (2) @(negedge clk);

    // rst  req   gnt  rv  err  exp_gnt sreq win perr
    vt.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0)); // reset state
    vt.push_back(mk(0, 2'b11, 1, 0, 0, 2'b01, 1, 0, 0)); // tie -> m0 first
    vt.push_back(mk(0, 2'b11, 1, 1, 0, 2'b10, 1, 1, 0));
    vt.push_back(mk(0, 2'b11, 1, 1, 0, 2'b01, 1, 0, 0));
    vt.push_back(mk(0, 2'b11, 1, 1, 0, 2'b10, 1, 1, 0));
    vt.push_back(mk(0, 2'b00, 0, 1, 1, 2'b00, 0, 0, 0)); // error routed to m1
    vt.push_back(mk(0, 2'b10, 1, 0, 0, 2'b10, 1, 1, 0)); // m1 alone reads 0x40
    vt.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 2'b01, 1, 0, 0, 2'b01, 1, 0, 0)); // make m0 last winner
    vt.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 2'b01, 0, 0, 0, 2'b00, 1, 0, 0)); // m0 stalled -> lock
    vt.push_back(mk(0, 2'b01, 0, 0, 0, 2'b00, 1, 0, 0));
    vt.push_back(mk(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0)); // m1 joins, lock holds m0
    vt.push_back(mk(0, 2'b11, 1, 0, 0, 2'b01, 1, 0, 0));
    vt.push_back(mk(0, 2'b10, 1, 0, 0, 2'b10, 1, 1, 0));
    vt.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 2'b11, 1, 0, 0, 2'b01, 1, 0, 0)); // fill FIFO
    vt.push_back(mk(0, 2'b11, 1, 0, 0, 2'b10, 1, 1, 0));
    vt.push_back(mk(0, 2'b11, 1, 0, 0, 2'b00, 0, 0, 0)); // full
    vt.push_back(mk(0, 2'b11, 1, 1, 0, 2'b00, 0, 0, 0)); // pop does not unblock
    vt.push_back(mk(0, 2'b11, 1, 1, 0, 2'b01, 1, 0, 0)); // push+pop, no stall
    vt.push_back(mk(0, 2'b11, 1, 1, 0, 2'b10, 1, 1, 0));
    vt.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0)); // stray rvalid
    vt.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1)); // sticky
    vt.push_back(mk(0, 2'b01, 1, 0, 0, 2'b01, 1, 0, 1));
    vt.push_back(mk(0, 2'b01, 1, 0, 0, 2'b01, 1, 0, 1)); // two outstanding, last=m0
    vt.push_back(mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1)); // reset mid-transaction
    vt.push_back(mk(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0)); // FIFO empty, tie -> m0
    vt.push_back(mk(0, 2'b11, 1, 0, 0, 2'b01, 1, 0, 0));
    vt.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 2'b01, 0, 0, 0, 2'b00, 1, 0, 0)); // lock m0, then m0 gives up
    vt.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 2'b10, 1, 0, 0, 2'b10, 1, 1, 0)); // lock released
    vt.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Continuous contention with responses one cycle behind: strict alternation.
    for (int i = 0; i < 8; i++)
      apply(mk(0, 2'b11, 1, (i > 0), 0, (i % 2 == 0) ? 2'b01 : 2'b10, 1, (i % 2 == 1), 0), 100 + i);
    apply(mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0), 108);
    apply(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0), 109);
    chk("sb_drained", 110, 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
